// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// mult/multu run radix-2 shift-add and div/divu run restoring division, each taking WIDTH cycles.
//
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo accepted here
// MUL    | WIDTH shift-add iterations on magnitudes
// DIV    | WIDTH restoring-division iterations on magnitudes
// FIX    | sign correction; HI/LO committed at the exit edge
// DONE   | done_o pulse, result visible on hi_o/lo_o
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dvz;
    logic               r_dvz_flag;
    logic [WIDTH-1:0]   r_src1;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag1;
    logic [WIDTH-1:0]   w_mag2;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed = ~op_i[0];
    assign w_mag1   = (w_signed && src1_i[WIDTH-1]) ? -src1_i : src1_i;
    assign w_mag2   = (w_signed && src2_i[WIDTH-1]) ? -src2_i : src2_i;

    // Accumulator low half holds the unconsumed multiplier bits; the product grows in from the top.
    assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

    // Upper half is the partial remainder, low half shifts dividend out and quotient bits in.
    assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_b};
    assign w_ge      = (w_rem_sh >= {1'b0, r_b});
    assign w_div_nxt = {(w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    assign w_prod    = r_neg_res ? -r_acc : r_acc;
    assign w_quo_fix = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dvz      <= 1'b0;
            r_dvz_flag <= 1'b0;
            r_src1     <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_is_div  <= op_i[1];
                        r_neg_res <= w_signed & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
                        r_neg_rem <= w_signed & src1_i[WIDTH-1];
                        r_dvz     <= op_i[1] & (src2_i == '0);
                        r_src1    <= src1_i;
                        r_b       <= w_mag2;
                        r_acc     <= {{WIDTH{1'b0}}, w_mag1};
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_state   <= op_i[1] ? S_DIV : S_MUL;
                    end else begin
                        if (hi_we_i) r_hi <= wdata_i;
                        if (lo_we_i) r_lo <= wdata_i;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        r_hi       <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo       <= w_prod[WIDTH-1:0];
                        r_dvz_flag <= 1'b0;
                    end else if (r_dvz) begin
                        r_hi       <= r_src1;
                        r_lo       <= '1;
                        r_dvz_flag <= 1'b1;
                    end else begin
                        r_hi       <= w_rem_fix;
                        r_lo       <= w_quo_fix;
                        r_dvz_flag <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o        = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
    assign done_o        = (r_state == S_DONE);
    assign div_by_zero_o = r_dvz_flag;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed cases plus randomized ops against
// a plain-arithmetic reference model; a monitor checks every done_o pulse.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start_i = 1'b0;
    logic [1:0]   op_i    = '0;
    logic [W-1:0] src1_i  = '0;
    logic [W-1:0] src2_i  = '0;
    logic         hi_we_i = 1'b0;
    logic         lo_we_i = 1'b0;
    logic [W-1:0] wdata_i = '0;
    logic         busy_o;
    logic         done_o;
    logic         div_by_zero_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dvz;
        int           at_cyc;
        string        tag;
    } exp_t;

    exp_t sb[$];

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
        .src1_i(src1_i), .src2_i(src2_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
        .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
        .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference results straight from signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dvz = 1'b0; e.at_cyc = 0; e.tag = "";
        case (op)
            2'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = 64'(a) * 64'(b); e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dvz = 1'b1;
                end else if (op == 2'd2) begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[W-1:0]; e.hi = r[W-1:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d required no pending op", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.tag, "_hi"}, hi_o, e.hi);
                chk({e.tag, "_lo"}, lo_o, e.lo);
                chk({e.tag, "_dvz"}, div_by_zero_o, e.dvz);
                chk({e.tag, "_cycle"}, cyc, e.at_cyc);
                chk({e.tag, "_busy_at_done"}, busy_o, 0);
            end
        end
    end

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_o !== 1'b1 && k < W + 8) begin
            @(negedge clk_i);
            k++;
        end
        if (done_o !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no done_o in %0d cycles required done_o", tag, W + 8);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edvz,
                         input string tag);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
        sb.push_back('{hi: ehi, lo: elo, dvz: edvz, at_cyc: cyc + W + 2, tag: tag});
        @(negedge clk_i);
        start_i = 1'b0; src1_i = $urandom; src2_i = $urandom; op_i = 2'($urandom);
        chk({tag, "_busy"}, busy_o, 1);
        wait_done(tag);
    endtask

    task automatic issue_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input string tag);
        exp_t e;
        e = model(op, a, b);
        issue(op, a, b, e.hi, e.lo, e.dvz, tag);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_dvz", div_by_zero_o, 0);
        chk("rst_hi", hi_o, 0);
        chk("rst_lo", lo_o, 0);
        rst_n = 1'b1;

        issue(2'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, "mult_neg7");
        issue(2'd1, 32'hFFFF_FFFF, 32'd7, 32'h0000_0006, 32'hFFFF_FFF9, 1'b0, "multu");
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mult_min");
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        issue(2'd3, 32'hFFFF_FFF9, 32'd2, 32'h1, 32'h7FFF_FFFC, 1'b0, "divu");
        issue(2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, "divu_zero");
        @(negedge clk_i);
        chk("dvz_hold", div_by_zero_o, 1);
        issue(2'd2, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, "div_zero");
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");

        // Handshake: start and mthi during an op are ignored, HI/LO hold their last value.
        @(negedge clk_i);
        c = cyc;
        start_i = 1'b1; op_i = 2'd0; src1_i = 32'd3; src2_i = 32'd5;
        sb.push_back('{hi: 32'h0, lo: 32'd15, dvz: 1'b0, at_cyc: c + W + 2, tag: "hs_mult"});
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd2; src1_i = 32'd9; src2_i = 32'd3;
        hi_we_i = 1'b1; wdata_i = 32'hDEAD;
        @(negedge clk_i);
        start_i = 1'b0; hi_we_i = 1'b0;
        chk("hs_hi_stable", hi_o, 32'h0);
        chk("hs_lo_stable", lo_o, 32'h8000_0000);
        chk("hs_busy", busy_o, 1);
        wait_done("hs_mult");
        start_i = 1'b1; op_i = 2'd1; src1_i = 32'd4; src2_i = 32'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("done_start_ignored", busy_o, 0);
        hi_we_i = 1'b1; wdata_i = 32'hDEAD;
        @(negedge clk_i);
        hi_we_i = 1'b0;
        chk("mthi_hi", hi_o, 32'hDEAD);
        chk("mthi_lo", lo_o, 32'd15);
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h1234;
        @(negedge clk_i);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        chk("mthilo_hi", hi_o, 32'h1234);
        chk("mthilo_lo", lo_o, 32'h1234);
        start_i = 1'b1; op_i = 2'd0; src1_i = 32'hFFFF_FFFF; src2_i = 32'd2;
        hi_we_i = 1'b1; wdata_i = 32'hBEEF;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFE, dvz: 1'b0, at_cyc: cyc + W + 2, tag: "start_wins"});
        @(negedge clk_i);
        start_i = 1'b0; hi_we_i = 1'b0;
        chk("start_wins_hi", hi_o, 32'h1234);
        wait_done("start_wins");

        // Reset in the middle of a divide discards it entirely.
        @(negedge clk_i);
        start_i = 1'b1; op_i = 2'd2; src1_i = 32'd1000; src2_i = 32'd7;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_n = 1'b0;
        @(negedge clk_i);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_hi", hi_o, 0);
        chk("midrst_lo", lo_o, 0);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk_i);
        issue_model(2'd2, -32'sd1000, 32'd7, "post_rst_div");

        for (int i = 0; i < 60; i++) begin
            issue_model(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "rand");
        end

        repeat (3) @(negedge clk_i);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
